// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - SAP controller-sequencer: six-T-state ring and per-T-state control word
// Optional macro SINGLE_STEP_EN adds a step input; the ring then advances one T-state per step rising edge.
module ctrl_sequencer #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
`ifdef SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic [3:0] ir_op,
  output logic [5:0] tstate,
  output logic       t3,
  output logic       cp,
  output logic       ep,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb,
  output logic       lo,
  output logic       hlt
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } ring_t;

  ring_t ring_q, ring_d;
  logic  halted_q, halted_d;
  logic  advance;
  logic  ctl_en;

`ifdef SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end

  assign advance = run & ~halted_q & step & ~step_q;
`else
  assign advance = run & ~halted_q;
`endif

  // Controls only appear on cycles that actually advance, and never while reset is held.
  assign ctl_en = advance & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ring_q   <= T1;
      halted_q <= 1'b0;
    end else begin
      ring_q   <= ring_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    ring_d   = ring_q;
    halted_d = halted_q;
    case (ring_q)
      T1: if (advance) ring_d = T2;
      T2: if (advance) ring_d = T3;
      T3: if (advance) ring_d = T4;
      T4: begin
        if (advance) begin
          if (ir_op == OP_HLT) halted_d = 1'b1;
          else                 ring_d   = T5;
        end
      end
      T5: if (advance) ring_d = T6;
      T6: if (advance) ring_d = T1;
      default: ring_d = T1;
    endcase
  end

  always_comb begin
    cp = 1'b0;
    ep = 1'b0;
    lm = 1'b0;
    ce = 1'b0;
    li = 1'b0;
    ei = 1'b0;
    la = 1'b0;
    ea = 1'b0;
    su = 1'b0;
    eu = 1'b0;
    lb = 1'b0;
    lo = 1'b0;
    if (ctl_en) begin
      case (ring_q)
        T1: begin
          ep = 1'b1;
          lm = 1'b1;
        end
        T2: cp = 1'b1;
        T3: begin
          ce = 1'b1;
          li = 1'b1;
        end
        T4: begin
          case (ir_op)
            OP_LDA, OP_ADD, OP_SUB: begin
              ei = 1'b1;
              lm = 1'b1;
            end
            OP_OUT: begin
              ea = 1'b1;
              lo = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          case (ir_op)
            OP_LDA: begin
              ce = 1'b1;
              la = 1'b1;
            end
            OP_ADD: begin
              ce = 1'b1;
              lb = 1'b1;
            end
            // su leads into T6 so the ALU output has settled before eu.
            OP_SUB: begin
              ce = 1'b1;
              lb = 1'b1;
              su = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          case (ir_op)
            OP_ADD: begin
              eu = 1'b1;
              la = 1'b1;
            end
            OP_SUB: begin
              eu = 1'b1;
              la = 1'b1;
              su = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign tstate = ring_q;
  assign t3     = (ring_q == T3);
  assign hlt    = halted_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - directed and randomized checks of ctrl_sequencer against a T-state model
module tb_ctrl_sequencer;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam int B_T3 = 13, B_CP = 12, B_EP = 11, B_LM = 10, B_CE = 9, B_LI = 8, B_EI = 7;
  localparam int B_LA = 6, B_EA = 5, B_SU = 4, B_EU = 3, B_LB = 2, B_LO = 1, B_HLT = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [3:0] ir_op;
`ifdef SINGLE_STEP_EN
  logic       step;
`endif
  logic [5:0] tstate;
  logic       t3, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;
  logic [13:0] dut_word;

  int errors = 0;
  int checks = 0;

  int m_t;
  bit m_halted;
  bit m_prev_step;

  always #5 clk = ~clk;

  ctrl_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
`ifdef SINGLE_STEP_EN
    .step   (step),
`endif
    .ir_op  (ir_op),
    .tstate (tstate),
    .t3     (t3),
    .cp     (cp),
    .ep     (ep),
    .lm     (lm),
    .ce     (ce),
    .li     (li),
    .ei     (ei),
    .la     (la),
    .ea     (ea),
    .su     (su),
    .eu     (eu),
    .lb     (lb),
    .lo     (lo),
    .hlt    (hlt)
  );

  assign dut_word = {t3, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control word demanded by each T-state of each instruction.
  function automatic logic [13:0] ctl_word(input int t, input logic [3:0] op);
    logic [13:0] w;
    bit          mem_op;
    w      = '0;
    mem_op = (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
    case (t)
      1: begin w[B_EP] = 1'b1; w[B_LM] = 1'b1; end
      2: w[B_CP] = 1'b1;
      3: begin w[B_CE] = 1'b1; w[B_LI] = 1'b1; end
      4: begin
        if (mem_op) begin w[B_EI] = 1'b1; w[B_LM] = 1'b1; end
        else if (op == OP_OUT) begin w[B_EA] = 1'b1; w[B_LO] = 1'b1; end
      end
      5: begin
        if (mem_op) begin
          w[B_CE] = 1'b1;
          if (op == OP_LDA) w[B_LA] = 1'b1;
          else              w[B_LB] = 1'b1;
          w[B_SU] = (op == OP_SUB);
        end
      end
      6: begin
        if (op == OP_ADD || op == OP_SUB) begin
          w[B_EU] = 1'b1;
          w[B_LA] = 1'b1;
          w[B_SU] = (op == OP_SUB);
        end
      end
      default: ;
    endcase
    return w;
  endfunction

  function automatic bit model_adv();
`ifdef SINGLE_STEP_EN
    return run && !m_halted && step && !m_prev_step;
`else
    return run && !m_halted;
`endif
  endfunction

  function automatic logic [13:0] model_expect();
    logic [13:0] w;
    w = '0;
    if (m_halted) w[B_HLT] = 1'b1;
    else begin
      w[B_T3] = (m_t == 3);
      if (rst_n && model_adv()) w = w | ctl_word(m_t, ir_op);
    end
    return w;
  endfunction

  task automatic model_reset();
    m_t         = 1;
    m_halted    = 1'b0;
    m_prev_step = 1'b0;
  endtask

  // Called just after a falling edge with inputs settled; returns at the next falling edge.
  task automatic cyc(input string tag);
    logic [5:0] exp_t;
    #1;
    exp_t = 6'(1 << (m_t - 1));
    check({tag, " tstate"}, tstate, exp_t);
    check({tag, " ctl"}, dut_word, model_expect());
    check({tag, " bus"}, ($countones({ep, ce, ei, ea, eu}) <= 1), 1);
    @(posedge clk);
    if (rst_n) begin
      if (model_adv()) begin
        if (m_t == 4 && ir_op == OP_HLT) m_halted = 1'b1;
        else                             m_t = (m_t % 6) + 1;
      end
`ifdef SINGLE_STEP_EN
      m_prev_step = step;
`endif
    end
    @(negedge clk);
  endtask

  initial begin
    int sel;
    rst_n = 1'b0;
    run   = 1'b1;
    ir_op = OP_LDA;
`ifdef SINGLE_STEP_EN
    step  = 1'b0;
`endif
    model_reset();
    @(negedge clk);
    cyc("reset");
    cyc("reset");
    check("reset tstate", tstate, 6'b000001);
    check("reset hlt", hlt, 1'b0);

`ifndef SINGLE_STEP_EN
    rst_n = 1'b1;
    #1 check("lda t1 ep lm", {ep, lm}, 2'b11);
    repeat (6) cyc("lda");
    check("lda wrap", tstate, 6'b000001);

    ir_op = OP_ADD;
    repeat (6) cyc("add");
    ir_op = OP_SUB;
    repeat (4) cyc("sub");
    #1 check("sub t5", {ce, lb, su}, 3'b111);
    cyc("sub t5");
    #1 check("sub t6", {eu, la, su}, 3'b111);
    cyc("sub t6");
    ir_op = OP_OUT;
    repeat (3) cyc("out");
    #1 check("out t4", {ea, lo}, 2'b11);
    repeat (3) cyc("out");

    ir_op = OP_HLT;
    repeat (4) cyc("hlt fetch");
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom_range(0, 1));
      cyc("halted");
    end
    #1 check("halted hlt", hlt, 1'b1);
    check("halted tstate", tstate, 6'b001000);
    check("halted word", dut_word, 14'd1);
    rst_n = 1'b0;
    model_reset();
    #1 check("halt clear tstate", tstate, 6'b000001);
    check("halt clear hlt", hlt, 1'b0);
    cyc("halt reset");
    rst_n = 1'b1;

    run   = 1'b1;
    ir_op = OP_LDA;
    cyc("pause t1");
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc("pause");
      check("pause tstate", tstate, 6'b000010);
      check("pause cp", cp, 1'b0);
    end
    run = 1'b1;
    #1 check("resume cp", cp, 1'b1);
    cyc("resume");
    #1 check("resume t3", {tstate, t3, cp}, {6'b000100, 1'b1, 1'b0});
    ir_op = OP_ADD;
    cyc("add t3");
    cyc("add t4");
    #1 check("add t5 lb", {ce, lb}, 2'b11);
    #1 rst_n = 1'b0;
    #1 check("async rst tstate", tstate, 6'b000001);
    check("async rst la lb", {la, lb}, 2'b00);
    model_reset();
    cyc("async rst");
    rst_n = 1'b1;
    cyc("post rst t1");
`else
    rst_n = 1'b1;
    step  = 1'b1;
    for (int i = 0; i < 10; i++) cyc("step held");
    #1 check("step held tstate", tstate, 6'b000010);
    step = 1'b0;
    cyc("step low");
    rst_n = 1'b0;
    model_reset();
    cyc("step rst");
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      if (k == 1) #1 check("step t2 cp", cp, 1'b1);
      cyc("step press");
      step = 1'b0;
      #1 check("step idle cp", cp, 1'b0);
      cyc("step release");
    end
    check("step three", tstate, 6'b001000);
`endif

    for (int i = 0; i < 400; i++) begin
      if (!rst_n) rst_n = 1'b1;
      else if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 63) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end
      run = ($urandom_range(0, 7) != 0);
      if (m_t == 1) begin
        sel = $urandom_range(0, 9);
        case (sel)
          0, 1:    ir_op = OP_LDA;
          2, 3:    ir_op = OP_ADD;
          4, 5:    ir_op = OP_SUB;
          6, 7:    ir_op = OP_OUT;
          8:       ir_op = OP_HLT;
          default: ir_op = 4'($urandom_range(3, 13));
        endcase
      end
`ifdef SINGLE_STEP_EN
      step = 1'($urandom_range(0, 1));
`endif
      cyc("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
